// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state encodings and player/direction constants for the pong match sequencer
package pong_pkg;

  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_SERVE  = 3'd1;
  localparam state_t ST_PLAY   = 3'd2;
  localparam state_t ST_POINT  = 3'd3;
  localparam state_t ST_OVER   = 3'd4;
  localparam state_t ST_PAUSED = 3'd5;

  localparam logic PLAYER1   = 1'b0;
  localparam logic PLAYER2   = 1'b1;
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/pong_game_ctrl_if.sv
// rtl/pong_game_ctrl_if.sv - game-controller bus: vsync/buttons/miss events in, ball and score controls out
// pause_n exists only when PONG_PAUSE_EN is defined.
interface pong_game_ctrl_if
  import pong_pkg::*;
#(
  parameter int SCORE_W = 4
);
  logic               vsync;
  logic               start_n;
  logic               miss_left;
  logic               miss_right;
`ifdef PONG_PAUSE_EN
  logic               pause_n;
`endif
  logic               ball_hold;
  logic               ball_run;
  logic               serve_dir;
  logic               p1_score_pulse;
  logic               p2_score_pulse;
  logic [SCORE_W-1:0] p1_score;
  logic [SCORE_W-1:0] p2_score;
  logic               game_over;
  logic               winner;
  logic [STATE_W-1:0] state_o;

  modport master (
`ifdef PONG_PAUSE_EN
    output pause_n,
`endif
    output vsync, start_n, miss_left, miss_right,
    input  ball_hold, ball_run, serve_dir, p1_score_pulse, p2_score_pulse,
    input  p1_score, p2_score, game_over, winner, state_o
  );

  modport slave (
`ifdef PONG_PAUSE_EN
    input  pause_n,
`endif
    input  vsync, start_n, miss_left, miss_right,
    output ball_hold, ball_run, serve_dir, p1_score_pulse, p2_score_pulse,
    output p1_score, p2_score, game_over, winner, state_o
  );

endinterface

// File: rtl/pong_btn_edge.sv
// rtl/pong_btn_edge.sv - optional 2-flop synchroniser plus one-clk falling-edge detector
module pong_btn_edge #(
  parameter bit SYNC = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic fall_o
);

  logic lvl_q;
  logic prev_q;

  // Level flops reset low so a button already held at reset release never looks like a press.
  generate
    if (SYNC) begin : g_sync
      logic meta_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          meta_q <= 1'b0;
          lvl_q  <= 1'b0;
        end else begin
          meta_q <= btn_i;
          lvl_q  <= meta_q;
        end
      end
    end else begin : g_nosync
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lvl_q <= 1'b0;
        else        lvl_q <= btn_i;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= lvl_q;
  end

  assign fall_o = prev_q & ~lvl_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - pong match sequencer: serve/play/point/over flow, scores and ball controls
// Optional PONG_PAUSE_EN adds a pause button and a PAUSED state.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = 11,
  parameter int SCORE_W      = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30
) (
  input  logic             clk,
  input  logic             reset,
  pong_game_ctrl_if.slave  bus
);

  localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);
  localparam logic [7:0]         SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0]         POINT_LAST = 8'(POINT_FRAMES - 1);

  logic start_evt;
  logic frame_tick;
  logic pause_evt;

  pong_btn_edge #(.SYNC(1'b1)) u_start (
    .clk(clk), .rst_n(reset), .btn_i(bus.start_n), .fall_o(start_evt)
  );

  pong_btn_edge #(.SYNC(1'b0)) u_vsync (
    .clk(clk), .rst_n(reset), .btn_i(bus.vsync), .fall_o(frame_tick)
  );

`ifdef PONG_PAUSE_EN
  pong_btn_edge #(.SYNC(1'b1)) u_pause (
    .clk(clk), .rst_n(reset), .btn_i(bus.pause_n), .fall_o(pause_evt)
  );
`else
  assign pause_evt = 1'b0;
`endif

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic               p1p_q, p1p_d, p2p_q, p2p_d;
  logic               go_q, go_d, win_q, win_d;
  logic               hold_q, hold_d, run_q, run_d;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s >= WIN) ? WIN : s + SCORE_W'(1);
  endfunction

  always_comb begin
    state_d = state_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    p1p_d   = 1'b0;
    p2p_d   = 1'b0;
    go_d    = go_q;
    win_d   = win_q;
    case (state_q)
      ST_IDLE: begin
        if (start_evt) begin
          p1_d    = '0;
          p2_d    = '0;
          dir_d   = DIR_RIGHT;
          cnt_d   = '0;
          state_d = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (frame_tick) begin
          if (cnt_q == SERVE_LAST) begin
            cnt_d   = '0;
            state_d = ST_PLAY;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_PLAY: begin
        if (pause_evt) begin
          state_d = ST_PAUSED;
        end else if (bus.miss_left || bus.miss_right) begin
          cnt_d   = '0;
          state_d = ST_POINT;
          // A double miss is a void rally: nobody scores and the serve side stays.
          if (bus.miss_left && !bus.miss_right) begin
            p2_d  = sat_inc(p2_q);
            p2p_d = 1'b1;
            dir_d = DIR_LEFT;
          end else if (bus.miss_right && !bus.miss_left) begin
            p1_d  = sat_inc(p1_q);
            p1p_d = 1'b1;
            dir_d = DIR_RIGHT;
          end
        end
      end
      ST_POINT: begin
        if (frame_tick) begin
          if (cnt_q == POINT_LAST) begin
            cnt_d = '0;
            if (p1_q == WIN || p2_q == WIN) begin
              go_d    = 1'b1;
              win_d   = (p2_q == WIN) ? PLAYER2 : PLAYER1;
              state_d = ST_OVER;
            end else begin
              state_d = ST_SERVE;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_OVER: begin
        if (start_evt) begin
          p1_d    = '0;
          p2_d    = '0;
          go_d    = 1'b0;
          win_d   = PLAYER1;
          dir_d   = DIR_RIGHT;
          cnt_d   = '0;
          state_d = ST_SERVE;
        end
      end
`ifdef PONG_PAUSE_EN
      ST_PAUSED: begin
        if (pause_evt) state_d = ST_PLAY;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Ball controls follow the next state so they land in the same clk as the state change.
  always_comb begin
    hold_d = 1'b1;
    run_d  = 1'b0;
    if (state_d == ST_PLAY) begin
      hold_d = 1'b0;
      run_d  = 1'b1;
    end else if (state_d == ST_PAUSED) begin
      hold_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      p1_q    <= '0;
      p2_q    <= '0;
      cnt_q   <= '0;
      dir_q   <= DIR_RIGHT;
      p1p_q   <= 1'b0;
      p2p_q   <= 1'b0;
      go_q    <= 1'b0;
      win_q   <= PLAYER1;
      hold_q  <= 1'b1;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      p1p_q   <= p1p_d;
      p2p_q   <= p2p_d;
      go_q    <= go_d;
      win_q   <= win_d;
      hold_q  <= hold_d;
      run_q   <= run_d;
    end
  end

  assign bus.ball_hold      = hold_q;
  assign bus.ball_run       = run_q;
  assign bus.serve_dir      = dir_q;
  assign bus.p1_score_pulse = p1p_q;
  assign bus.p2_score_pulse = p2p_q;
  assign bus.p1_score       = p1_q;
  assign bus.p2_score       = p2_q;
  assign bus.game_over      = go_q;
  assign bus.winner         = win_q;
  assign bus.state_o        = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - scoreboard bench for pong_game_ctrl: expected output changes queued, monitor compares
module tb_pong_game_ctrl;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   frames = 0;

  pong_game_ctrl_if #(.SCORE_W(4)) bus ();

  pong_game_ctrl #(
    .WIN_SCORE(11), .SCORE_W(4), .SERVE_FRAMES(60), .POINT_FRAMES(30)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // vsync low for 2 clks every 8; frames counts the edge at which the DUT consumes each tick
  initial begin : vsync_gen
    int vph;
    vph = 0;
    bus.vsync = 1'b1;
    forever begin
      @(posedge clk);
      if (vph == 2) frames++;
      #1;
      if (vph == 0) bus.vsync = 1'b0;
      if (vph == 2) bus.vsync = 1'b1;
      vph = (vph + 1) % 8;
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  string       name_q[$];
  logic [17:0] val_q[$];
  int          cyc_q[$];
  int          frm_q[$];

  function automatic logic [17:0] sample();
    return {bus.state_o, bus.p1_score, bus.p2_score, bus.p1_score_pulse, bus.p2_score_pulse,
            bus.ball_hold, bus.ball_run, bus.serve_dir, bus.game_over, bus.winner};
  endfunction

  task automatic expect_out(input string name, input logic [2:0] st, input int s1, input int s2,
                            input bit pp1, input bit pp2, input bit hold, input bit run,
                            input bit dir, input bit go, input bit win, input int cyc, input int frm);
    name_q.push_back(name);
    val_q.push_back({st, 4'(s1), 4'(s2), pp1, pp2, hold, run, dir, go, win});
    cyc_q.push_back(cyc);
    frm_q.push_back(frm);
  endtask

  initial begin : monitor
    logic [17:0] cur, prev, e;
    int          ncyc, last_cyc, last_frm, ec, ef;
    string       nm;
    prev = 'x;
    ncyc = 0;
    last_cyc = 0;
    last_frm = 0;
    forever begin
      @(negedge clk);
      ncyc++;
      cur = sample();
      if (cur !== prev) begin
        checks++;
        if (val_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: got %h (was %h) at cycle %0d", cur, prev, ncyc);
        end else begin
          nm = name_q.pop_front();
          e  = val_q.pop_front();
          ec = cyc_q.pop_front();
          ef = frm_q.pop_front();
          if (cur !== e) begin
            errors++;
            $display("FAIL %s: outputs got %h, expected %h", nm, cur, e);
          end else if (ec >= 0 && ncyc - last_cyc != ec) begin
            errors++;
            $display("FAIL %s: %0d clks since last change, expected %0d", nm, ncyc - last_cyc, ec);
          end else if (ef >= 0 && frames - last_frm != ef) begin
            errors++;
            $display("FAIL %s: %0d frames in previous state, expected %0d", nm, frames - last_frm, ef);
          end
        end
        if (cur[17:15] !== prev[17:15]) last_frm = frames;
        last_cyc = ncyc;
        prev = cur;
      end
    end
  end

  task automatic wait_drain(input int budget, input string what);
    int n;
    n = 0;
    while (val_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (val_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d expected changes still pending, required 0", what, val_q.size());
      name_q.delete(); val_q.delete(); cyc_q.delete(); frm_q.delete();
    end
  endtask

  task automatic press_start();
    @(posedge clk); #1 bus.start_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.start_n = 1'b1;
  endtask

`ifdef PONG_PAUSE_EN
  task automatic press_pause();
    @(posedge clk); #1 bus.pause_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.pause_n = 1'b1;
  endtask
`endif

  task automatic drive_miss(input bit l, input bit r);
    @(posedge clk); #1 bus.miss_left = l; bus.miss_right = r;
    @(posedge clk); #1 bus.miss_left = 1'b0; bus.miss_right = 1'b0;
  endtask

  // mode 0: right miss (p1 scores), 1: left miss (p2 scores), 2: both
  task automatic play_point(input int mode, input int s1, input int s2, input bit dir);
    expect_out("point_enter", 3'd3, s1, s2, mode == 0, mode == 1, 1'b1, 1'b0, dir, 1'b0, 1'b0, -1, -1);
    if (mode != 2)
      expect_out("pulse_end", 3'd3, s1, s2, 1'b0, 1'b0, 1'b1, 1'b0, dir, 1'b0, 1'b0, 1, -1);
    if (s1 == 11) begin
      expect_out("game_over", 3'd4, s1, s2, 1'b0, 1'b0, 1'b1, 1'b0, dir, 1'b1, 1'b0, -1, 30);
    end else begin
      expect_out("serve_after_point", 3'd1, s1, s2, 1'b0, 1'b0, 1'b1, 1'b0, dir, 1'b0, 1'b0, -1, 30);
      expect_out("play_after_serve", 3'd2, s1, s2, 1'b0, 1'b0, 1'b0, 1'b1, dir, 1'b0, 1'b0, -1, 60);
    end
    drive_miss(mode != 0, mode != 1);
    wait_drain(3000, "point");
  endtask

  initial begin : stimulus
    reset = 1'b0;
    bus.start_n = 1'b1;
    bus.miss_left = 1'b0;
    bus.miss_right = 1'b0;
`ifdef PONG_PAUSE_EN
    bus.pause_n = 1'b1;
`endif
    expect_out("reset_state", 3'd0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    wait_drain(10, "reset");

    expect_out("first_serve", 3'd1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1);
    expect_out("first_play", 3'd2, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, -1, 60);
    press_start();
    wait_drain(2000, "first_serve");

    press_start();
    repeat (10) @(posedge clk);

    play_point(0, 1, 0, 1'b1);
    play_point(1, 1, 1, 1'b0);
    play_point(2, 1, 1, 1'b0);
    for (int i = 2; i <= 11; i++) play_point(0, i, 1, 1'b1);

    drive_miss(1'b1, 1'b0);
    drive_miss(1'b0, 1'b1);
    repeat (20) @(posedge clk);

    expect_out("restart_serve", 3'd1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1);
    expect_out("restart_play", 3'd2, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, -1, 60);
    press_start();
    wait_drain(2000, "restart");

`ifdef PONG_PAUSE_EN
    expect_out("paused", 3'd5, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1);
    press_pause();
    wait_drain(20, "pause");
    drive_miss(1'b1, 1'b0);
    repeat (10) @(posedge clk);
    expect_out("resumed", 3'd2, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, -1, -1);
    press_pause();
    wait_drain(20, "resume");
`endif

    play_point(0, 1, 0, 1'b1);

    expect_out("async_reset", 3'd0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1);
    @(posedge clk);
    #2 reset = 1'b0;
    bus.start_n = 1'b0;
    wait_drain(5, "async_reset");
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (20) @(posedge clk);
    #1 bus.start_n = 1'b1;
    repeat (20) @(posedge clk);

    expect_out("post_reset_serve", 3'd1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1);
    press_start();
    wait_drain(50, "post_reset_start");
    repeat (5) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Match sequencer for the pong game. Owns the serve/play/point/game-over flow, holds both players' scores and drives the ball's reset/run controls and the score displays' increment pulses. Sits beside the ball, paddle and score blocks on the pixel clock and uses VGA vsync as its frame timebase. Ball-exit events come from the ball/collision logic.

Parameters:
WIN_SCORE, 11, points needed to win; range 1..(2**SCORE_W)-1
SCORE_W, 4, score counter width
SERVE_FRAMES, 60, frames the ball is held at centre before a serve; range 1..255
POINT_FRAMES, 30, frames of pause after a point before the next serve; range 1..255

Ports:
clk  in  1  pixel clock, same as the VGA block
reset  in  1  asynchronous, active-low; 0 clears all state
vsync  in  1  VGA vsync, active-low pulse
start_n  in  1  start/restart button, active-low, asynchronous
miss_left  in  1  one-clk pulse: ball left the field past the player-1 (left) paddle
miss_right  in  1  one-clk pulse: ball left the field past the player-2 (right) paddle
ball_hold  out  1  1 = ball held at centre (ball reset)
ball_run  out  1  1 = ball may move
serve_dir  out  1  0 = serve leftward, 1 = serve rightward
p1_score_pulse  out  1  one-clk increment pulse to the p1 score display
p2_score_pulse  out  1  one-clk increment pulse to the p2 score display
p1_score  out  SCORE_W  player-1 score
p2_score  out  SCORE_W  player-2 score
game_over  out  1  match finished
winner  out  1  0 = p1, 1 = p2; valid while game_over
state_o  out  3  encoded FSM state, for debug

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; scores 0; frame counter 0; ball_hold=1, ball_run=0, serve_dir=1, score pulses 0, game_over=0, winner=0.
- start_n passes through a 2-flop synchroniser. start_evt is a one-clk pulse on the synchronised 1->0 edge. Holding the button does not repeat the event.
- frame_tick is a one-clk pulse on the registered 1->0 edge of vsync, so there is exactly one per frame.
- Outputs are registered and update one clk after the causing event.
- State encodings: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.
- IDLE: ball_hold=1. On start_evt: clear both scores, set serve_dir=1, clear the frame counter, go to SERVE.
- SERVE: ball_hold=1. Frame counter increments on frame_tick. When the count reaches SERVE_FRAMES-1 and frame_tick is high: go to PLAY and clear the counter.
- PLAY: ball_hold=0, ball_run=1.
  - miss_left alone: p2 scores, p2_score_pulse=1 for one clk, serve_dir=0 (serve toward the conceding player), go to POINT.
  - miss_right alone: p1 scores, p1_score_pulse=1, serve_dir=1, go to POINT.
  - Both miss pulses in the same clk: no score, serve_dir unchanged, go to POINT.
- POINT: ball_hold=1. Miss pulses are ignored. After POINT_FRAMES frame_ticks:
  - if either score equals WIN_SCORE, go to OVER with game_over=1 and winner set;
  - otherwise go to SERVE.
- Score width rule: scores saturate at WIN_SCORE and never wrap.
- OVER: ball_hold=1, game_over=1. On start_evt: go to IDLE-equivalent, i.e. clear scores and game_over and go directly to SERVE.
- start_evt is ignored in SERVE, PLAY and POINT.
- reset asserted mid-match aborts immediately to the reset values. Scores are lost.
- Undefined state encodings recover to IDLE on the next clk.

Optional Feature:
PONG_PAUSE_EN
- Defined: adds input pause_n (active-low button, synchronised and edge-detected like start_n) and state PAUSED=5.
  - A pause event in PLAY goes to PAUSED: ball_run=0, ball_hold=0 (ball frozen in place).
  - A second pause event returns to PLAY. Miss pulses are ignored while PAUSED.
  - A pause event in other states is ignored.
- Undefined: no port, no state, and behaviour exactly as above.

Decomposition:
- Package pong_pkg holds the state encodings (IDLE..PAUSED), the state width 3, and the PLAYER1=0 / PLAYER2=1 and DIR_LEFT=0 / DIR_RIGHT=1 constants.
- One sub-module, pong_btn_edge: 2-flop synchroniser plus falling-edge detector. It is reused for start_n, pause_n and vsync (vsync skips the synchroniser via parameter SYNC=0).

Test Plan:
- Reset released, start_n pulse low 3 clks -> exactly one start_evt; SERVE for 60 frame_ticks, then ball_run=1 and serve_dir=1.
- In PLAY, miss_right pulse -> p1_score_pulse high 1 clk, p1_score=1, serve_dir=1; POINT lasts 30 frames, then SERVE.
- miss_left and miss_right in the same clk -> no score pulse, scores unchanged, POINT entered.
- p1 reaches 11 (WIN_SCORE) -> after POINT, game_over=1 and winner=0; further miss pulses ignored; start_evt -> scores 0 and SERVE.
- reset=0 asserted mid-PLAY, asynchronously between clk edges -> outputs reach reset values immediately; start_n held low through reset release produces no start_evt.
- With PONG_PAUSE_EN defined: pause in PLAY -> ball_run=0, ball_hold=0, miss_left ignored; second pause -> PLAY resumes.
